flash_audio_reader: RTL and testbench

Avalon-MM burst-read master that fetches 32-bit audio words from the on-chip audio flash data port. It buffers them in a small internal FIFO and streams them out as 16-bit PCM samples on a valid/ready interface toward the audio output path. Playback is controlled by a start pulse carrying a word start address and a word length.

---
 rtl/flash_audio_reader.sv | 160 ++++++++++++++++
 tb/tb_flash_audio_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_audio_reader.sv
// Avalon-MM burst-read master: fetches 32-bit audio words from flash into a small FIFO
// and streams them out as 16-bit PCM samples, low half first.
module flash_audio_reader #(
    parameter int ADDR_W     = 18,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_burstcount,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    output logic [15:0]       sample_data,
    output logic              sample_valid,
    input  logic              sample_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] remaining;
    logic [3:0]        beats;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              half;

    logic        abort_now, wr, hs, pop, last_word;
    logic [31:0] head, free_w, want_w;

    assign abort_now    = abort && (state != IDLE);
    assign wr           = (state == WAIT_DATA) && (beats != '0) && avm_readdatavalid && !abort;
    assign sample_valid = (count != '0);
    assign hs           = sample_valid && sample_ready;
    assign pop          = hs && half;
    assign head         = mem[rptr];
    assign sample_data  = !sample_valid ? 16'h0 : (half ? head[31:16] : head[15:0]);
    assign free_w       = 32'(FIFO_DEPTH) - 32'(count);
    assign want_w       = (32'(remaining) < 32'(BURST_LEN)) ? 32'(remaining) : 32'(BURST_LEN);
    // Final pop of the final word: nothing left to fetch and nothing in flight.
    assign last_word    = (state == WAIT_DATA) && (beats == '0) && (remaining == '0)
                          && pop && (count == CW'(1));

    always_ff @(posedge clk_clk) begin
        if (wr) mem[wptr] <= avm_readdata;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state          <= IDLE;
            next_addr      <= '0;
            remaining      <= '0;
            beats          <= '0;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            half           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
        end else begin
            done <= 1'b0;
            if (abort_now) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                half  <= 1'b0;
            end else begin
                if (wr)  wptr <= wptr + PW'(1);
                if (pop) rptr <= rptr + PW'(1);
                if (hs)  half <= ~half;
                count <= count + CW'(wr) - CW'(pop);
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (length != '0) begin
                            next_addr <= start_addr;
                            remaining <= length;
                            busy      <= 1'b1;
                            state     <= REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (abort) begin
                        avm_read <= 1'b0;
                        // An accepted burst still owes its beats; they must be drained.
                        if (avm_read && !avm_waitrequest) begin
                            beats <= avm_burstcount;
                            state <= FLUSH;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (avm_read) begin
                        if (!avm_waitrequest) begin
                            avm_read  <= 1'b0;
                            next_addr <= next_addr + ADDR_W'(avm_burstcount);
                            remaining <= remaining - ADDR_W'(avm_burstcount);
                            beats     <= avm_burstcount;
                            state     <= WAIT_DATA;
                        end
                    end else if (free_w >= want_w) begin
                        avm_read       <= 1'b1;
                        avm_address    <= next_addr;
                        avm_burstcount <= want_w[3:0];
                    end
                end
                WAIT_DATA: begin
                    if (abort) begin
                        if (beats == '0 || (beats == 4'd1 && avm_readdatavalid)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            beats <= beats - (avm_readdatavalid ? 4'd1 : 4'd0);
                            state <= FLUSH;
                        end
                    end else if (beats != '0) begin
                        if (avm_readdatavalid) begin
                            beats <= beats - 4'd1;
                            if (beats == 4'd1 && remaining != '0) state <= REQ;
                        end
                    end else if (last_word) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (avm_readdatavalid) begin
                        beats <= beats - 4'd1;
                        if (beats == 4'd1) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_audio_reader.sv
// Bench for flash_audio_reader: flash slave and sample sink models driven by random
// stall/valid/ready rates, checked against an address-to-sample reference queue.
module tb_flash_audio_reader;
    localparam int ADDR_W     = 18;
    localparam int BURST_LEN  = 8;
    localparam int FIFO_DEPTH = 16;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0, length = '0;
    logic              busy, done, avm_read, sample_valid;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_burstcount;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest, avm_readdatavalid, sample_ready;
    logic [15:0]       sample_data;

    flash_audio_reader #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start), .abort(abort),
        .start_addr(start_addr), .length(length), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state
    logic [15:0]       exp_q[$];
    logic [31:0]       beat_q[$];
    logic [ADDR_W-1:0] exp_next;
    int                exp_rem = 0;
    logic [31:0]       mem_ovr[int];
    logic [31:0]       seed;
    int burst_a_q[$], burst_c_q[$];
    int rdv_pct = 100, wr_pct = 0, rdy_pct = 100, beat_budget = -1, wr_hold = 0;
    int cyc = 0, accept_cnt = 0, accept_cyc = 0, read_cycles = 0, done_cnt = 0, samp_cnt = 0;
    int last_hs_cyc = -10, hold_seen = 0, hold_last_cyc = 0;
    bit zero_len = 1'b0, hold_ref = 1'b0;
    logic [ADDR_W+3:0] hold_triple;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
        return (32'(a) * 32'h9E3779B1) ^ seed;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Flash slave + sample sink + done monitor, all evaluated 1 time unit after the edge.
    initial begin
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; sample_ready = 1'b0;
        forever begin
            @(posedge clk_clk); #1;
            cyc++;
            if (avm_read) read_cycles++;
            if (beat_q.size() > 0 && beat_budget != 0 && int'($urandom_range(99)) < rdv_pct) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = beat_q.pop_front();
                if (beat_budget > 0) beat_budget--;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = $urandom;
            end
            if (avm_read) begin
                if (wr_hold > 0) begin
                    avm_waitrequest = 1'b1;
                    if (!hold_ref) begin
                        hold_ref = 1'b1;
                        hold_triple = {avm_address, avm_burstcount};
                    end else begin
                        check("hold_stable", {avm_address, avm_burstcount}, hold_triple);
                    end
                    hold_seen++;
                    hold_last_cyc = cyc;
                    wr_hold--;
                end else begin
                    avm_waitrequest = (int'($urandom_range(99)) < wr_pct);
                    if (!avm_waitrequest) begin
                        accept_cnt++;
                        accept_cyc = cyc;
                        burst_a_q.push_back(int'(avm_address));
                        burst_c_q.push_back(int'(avm_burstcount));
                        if (hold_ref) begin
                            check("hold_accept", {avm_address, avm_burstcount}, hold_triple);
                            hold_ref = 1'b0;
                        end
                        check("burst_addr", avm_address, exp_next);
                        check("burst_cnt", avm_burstcount, min2(BURST_LEN, exp_rem));
                        check("one_outstanding", beat_q.size(), 0);
                        for (int i = 0; i < int'(avm_burstcount); i++)
                            beat_q.push_back(word_of(avm_address + ADDR_W'(i)));
                        exp_next = avm_address + ADDR_W'(avm_burstcount);
                        exp_rem -= int'(avm_burstcount);
                    end
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(1));
            end
            sample_ready = (int'($urandom_range(99)) < rdy_pct);
            if (sample_valid && sample_ready) begin
                samp_cnt++;
                last_hs_cyc = cyc;
                check("sample_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("sample_data", sample_data, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 1'b0);
                check("done_drained", exp_q.size(), 0);
                if (!zero_len) check("done_timing", last_hs_cyc, cyc - 1);
            end
        end
    end

    task automatic go(input logic [ADDR_W-1:0] a, input int len);
        logic [31:0] w;
        zero_len = (len == 0);
        for (int i = 0; i < len; i++) begin
            w = word_of(a + ADDR_W'(i));
            exp_q.push_back(w[15:0]);
            exp_q.push_back(w[31:16]);
        end
        exp_next = a;
        exp_rem  = len;
        @(posedge clk_clk); #1;
        start_addr = a; length = ADDR_W'(len); start = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk_clk); #2;
            n++;
        end
        check("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic wait_accept(input int a0, input int limit);
        int n = 0;
        while (accept_cnt == a0 && n < limit) begin
            @(posedge clk_clk); #2;
            n++;
        end
        check("accept_seen", accept_cnt, a0 + 1);
    endtask

    initial begin
        int a0, s0, d0, r0, len;
        logic [ADDR_W-1:0] ad;
        seed = $urandom;

        // Reset state
        repeat (2) @(negedge clk_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_read", avm_read, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_addr", avm_address, 0);
        check("rst_bcnt", avm_burstcount, 0);
        check("rst_data", sample_data, 0);
        @(negedge clk_clk); reset_reset_n = 1'b1;

        // Single 3-word burst with known words
        mem_ovr[16] = 32'hBBBBAAAA; mem_ovr[17] = 32'hDDDDCCCC; mem_ovr[18] = 32'hFFFFEEEE;
        a0 = accept_cnt; s0 = samp_cnt; d0 = done_cnt;
        go(18'h00010, 3);
        check("t1_busy", busy, 1'b1);
        wait_done(200);
        repeat (5) @(posedge clk_clk); #2;
        check("t1_bursts", accept_cnt - a0, 1);
        check("t1_addr", burst_a_q[$], 16);
        check("t1_bcnt", burst_c_q[$], 3);
        check("t1_samples", samp_cnt - s0, 6);
        check("t1_done_once", done_cnt - d0, 1);

        // Backpressure withholds the third burst until space frees up
        rdy_pct = 0; a0 = accept_cnt; s0 = samp_cnt;
        go(18'h00000, 20);
        repeat (60) @(posedge clk_clk); #2;
        check("t2_two_bursts", accept_cnt - a0, 2);
        check("t2_withheld", avm_read, 1'b0);
        check("t2_busy", busy, 1'b1);
        check("t2_b1_addr", burst_a_q[burst_a_q.size()-2], 0);
        check("t2_b2_addr", burst_a_q[$], 8);
        rdy_pct = 100;
        wait_done(400);
        check("t2_three_bursts", accept_cnt - a0, 3);
        check("t2_b3_addr", burst_a_q[$], 16);
        check("t2_b3_cnt", burst_c_q[$], 4);
        check("t2_samples", samp_cnt - s0, 40);

        // Waitrequest held for 5 cycles on the first request
        a0 = accept_cnt; hold_seen = 0; wr_hold = 5;
        go(18'h00100, 5);
        wait_done(200);
        check("t3_hold_cycles", hold_seen, 5);
        check("t3_accepts", accept_cnt - a0, 1);
        check("t3_accept_after_hold", accept_cyc, hold_last_cyc + 1);

        // Address wrap
        a0 = accept_cnt;
        go(18'h3FFFC, 8);
        wait_done(200);
        check("t4_accepts", accept_cnt - a0, 1);
        check("t4_addr", burst_a_q[$], 32'h3FFFC);
        check("t4_bcnt", burst_c_q[$], 8);
        check("t4_next_addr", dut.next_addr, 18'h00004);

        // Abort with 6 beats pending
        rdy_pct = 0; beat_budget = 0; a0 = accept_cnt; d0 = done_cnt;
        go(18'h00200, 8);
        wait_accept(a0, 50);
        beat_budget = 2;
        repeat (2) @(posedge clk_clk);
        @(posedge clk_clk); #1; abort = 1'b1;
        @(posedge clk_clk); #1; abort = 1'b0;
        exp_q.delete(); exp_rem = 0;
        #1;
        check("t5_valid_cleared", sample_valid, 1'b0);
        check("t5_busy_flush", busy, 1'b1);
        check("t5_pending", beat_q.size(), 6);
        beat_budget = -1; rdv_pct = 100;
        for (int n = 0; n < 50 && beat_q.size() > 0; n++) begin
            @(posedge clk_clk); #2;
        end
        check("t5_beats_drained", beat_q.size(), 0);
        @(posedge clk_clk); #2;
        check("t5_busy_low", busy, 1'b0);
        check("t5_valid_low", sample_valid, 1'b0);
        repeat (3) @(posedge clk_clk); #2;
        check("t5_no_done", done_cnt, d0);
        rdy_pct = 100; s0 = samp_cnt;
        go(18'h00300, 10);
        wait_done(300);
        check("t5_restart_samples", samp_cnt - s0, 20);

        // Zero length: done next cycle, no read
        r0 = read_cycles; d0 = done_cnt;
        go(18'h00055, 0);
        #1;
        check("t6_done", done, 1'b1);
        check("t6_busy", busy, 1'b0);
        repeat (5) @(posedge clk_clk); #2;
        check("t6_no_read", read_cycles, r0);
        check("t6_done_once", done_cnt, d0 + 1);

        // Reset mid-burst
        rdv_pct = 50; a0 = accept_cnt; d0 = done_cnt;
        go(18'h00400, 16);
        wait_accept(a0, 50);
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk); reset_reset_n = 1'b0;
        #1;
        check("t7_busy", busy, 1'b0);
        check("t7_read", avm_read, 1'b0);
        check("t7_valid", sample_valid, 1'b0);
        check("t7_addr", avm_address, 0);
        check("t7_bcnt", avm_burstcount, 0);
        check("t7_data", sample_data, 0);
        check("t7_done", done, 1'b0);
        repeat (3) @(negedge clk_clk);
        beat_q.delete(); exp_q.delete(); exp_rem = 0;
        reset_reset_n = 1'b1;
        check("t7_no_done", done_cnt, d0);

        // Randomized playbacks
        for (int t = 0; t < 8; t++) begin
            wr_pct  = int'($urandom_range(50));
            rdv_pct = 40 + int'($urandom_range(60));
            rdy_pct = 20 + int'($urandom_range(80));
            ad  = ADDR_W'($urandom);
            len = 1 + int'($urandom_range(39));
            s0 = samp_cnt;
            go(ad, len);
            wait_done(4000);
            check("rand_samples", samp_cnt - s0, 2 * len);
            check("rand_busy", busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
